sdpll_lock_ctrl: RTL

- Acquisition/lock sequencer for the square-wave sdpll.
- Loads the nominal phase step into the PLL, then starts with a wide loop bandwidth (small i_lgcoeff).
- Narrows the bandwidth step by step while windowed error counts stay low, then declares lock.
- Watches for loss of lock and restarts acquisition. Sits between the system control registers and the sdpll config/err ports.

---
 rtl/sdpll_ctrl_pkg.sv | 15 +
 rtl/sdpll_err_window.sv | 49 ++++
 rtl/sdpll_lock_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sdpll_ctrl_pkg.sv
// rtl/sdpll_ctrl_pkg.sv - shared state encoding and PLL error codes for the sdpll lock controller
package sdpll_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      ACQUIRE = 3'd2,
      LOCKED  = 3'd3
   } lock_state_t;

   localparam logic [1:0] PLL_ERR_NONE = 2'b00;
   localparam logic [1:0] PLL_ERR_LAG  = 2'b01;
   localparam logic [1:0] PLL_ERR_LEAD = 2'b11;

endpackage

// File: rtl/sdpll_err_window.sv
// rtl/sdpll_err_window.sv - windowed error counter over PLL-qualified samples
module sdpll_err_window
   import sdpll_ctrl_pkg::*;
#(
   parameter int unsigned LGWIN = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_clear,
   input  logic             i_ce,
   input  logic [1:0]       i_err,
   output logic             o_win_end,
   output logic [LGWIN:0]   o_win_errs
);

   logic               r_ce_d;
   logic [LGWIN-1:0]   r_win_cnt;
   logic [LGWIN:0]     r_err_cnt;
   logic               w_qual;
   logic               w_is_err;
   logic [LGWIN:0]     w_err_next;

   // The PLL publishes o_err on the cycle after its own i_ce, so qualify on the delayed enable.
   assign w_qual     = r_ce_d && !i_clear;
   assign w_is_err   = (i_err != PLL_ERR_NONE);
   assign w_err_next = (w_is_err && (r_err_cnt != '1))
                     ? r_err_cnt + {{LGWIN{1'b0}}, 1'b1} : r_err_cnt;

   assign o_win_end  = w_qual && (r_win_cnt == '1);
   assign o_win_errs = w_err_next;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_ce_d    <= 1'b0;
         r_win_cnt <= '0;
         r_err_cnt <= '0;
      end else begin
         r_ce_d <= i_ce;
         if (i_clear || o_win_end) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
         end else if (w_qual) begin
            r_win_cnt <= r_win_cnt + {{(LGWIN-1){1'b0}}, 1'b1};
            r_err_cnt <= w_err_next;
         end
      end
   end

endmodule

// File: rtl/sdpll_lock_ctrl.sv
// rtl/sdpll_lock_ctrl.sv - sdpll acquisition/lock sequencer; SDPLL_LOCK_CTRL_STATS_EN adds a relock counter
module sdpll_lock_ctrl
   import sdpll_ctrl_pkg::*;
#(
   parameter int unsigned PHASE_BITS    = 32,
   parameter int unsigned LGWIN         = 8,
   parameter int unsigned LGCOEFF_START = 4,
   parameter int unsigned LGCOEFF_FINAL = 10,
   parameter int unsigned GOOD_WINDOWS  = 2,
   parameter int unsigned LOCK_THRESH   = 8,
   parameter int unsigned UNLOCK_THRESH = 32,
   parameter int unsigned MAX_WINDOWS   = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [PHASE_BITS-2:0] i_nominal_step,
   input  logic                  i_ce,
   input  logic [1:0]            i_err,
   output logic                  o_ld,
   output logic [PHASE_BITS-2:0] o_step,
   output logic [4:0]            o_lgcoeff,
   output logic                  o_locked,
   output logic                  o_lost,
   output logic [2:0]            o_state,
   output logic [15:0]           o_relock_count
);

   localparam int unsigned    EW       = LGWIN + 1;
   localparam logic [EW-1:0]  LOCK_TH  = LOCK_THRESH[EW-1:0];
   localparam logic [EW-1:0]  UNLOCK_TH = UNLOCK_THRESH[EW-1:0];
   localparam logic [15:0]    GOOD_N   = GOOD_WINDOWS[15:0];
   localparam logic [15:0]    MAX_N    = MAX_WINDOWS[15:0];
   localparam logic [4:0]     COEF_LO  = LGCOEFF_START[4:0];
   localparam logic [4:0]     COEF_HI  = LGCOEFF_FINAL[4:0];

   lock_state_t             r_state;
   logic                    r_ld;
   logic                    r_locked;
   logic                    r_lost;
   logic [PHASE_BITS-2:0]   r_step;
   logic [4:0]              r_lgcoeff;
   logic [15:0]             r_good_cnt;
   logic [15:0]             r_tmo_cnt;

   logic                    w_clear;
   logic                    w_win_end;
   logic [EW-1:0]           w_win_errs;
   logic                    w_eval;
   logic                    w_good_win;
   logic [15:0]             w_good_next;
   logic [15:0]             w_tmo_next;
   logic                    w_advance;
   logic                    w_timeout;
   logic                    w_unlock;
   logic                    w_lost_evt;
   logic                    w_enter_load;

   // Counters only run while the loop is actually being measured.
   assign w_clear = (r_state == IDLE) || (r_state == LOAD);

   sdpll_err_window #(
      .LGWIN (LGWIN)
   ) u_err_window (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_clear    (w_clear),
      .i_ce       (i_ce),
      .i_err      (i_err),
      .o_win_end  (w_win_end),
      .o_win_errs (w_win_errs)
   );

   assign w_eval       = w_win_end && !i_abort && !i_start;
   assign w_good_win   = (w_win_errs <= LOCK_TH);
   assign w_good_next  = r_good_cnt + 16'd1;
   assign w_tmo_next   = r_tmo_cnt + 16'd1;
   assign w_advance    = w_eval && (r_state == ACQUIRE) && w_good_win && (w_good_next >= GOOD_N);
   // A window that earns a narrowing step is progress, so it never also times out.
   assign w_timeout    = w_eval && (r_state == ACQUIRE) && !w_advance && (w_tmo_next >= MAX_N);
   assign w_unlock     = w_eval && (r_state == LOCKED) && (w_win_errs >= UNLOCK_TH);
   assign w_lost_evt   = w_timeout || w_unlock;
   assign w_enter_load = !i_abort && (i_start || w_lost_evt);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_ld       <= 1'b0;
         r_locked   <= 1'b0;
         r_lost     <= 1'b0;
         r_step     <= '0;
         r_lgcoeff  <= COEF_LO;
         r_good_cnt <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         r_ld   <= w_enter_load;
         r_lost <= w_lost_evt;
         if (i_abort) begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
            r_tmo_cnt  <= '0;
         end else if (w_enter_load) begin
            r_state    <= LOAD;
            r_step     <= i_nominal_step;
            r_lgcoeff  <= COEF_LO;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
            r_tmo_cnt  <= '0;
         end else begin
            case (r_state)
               LOAD: r_state <= ACQUIRE;
               ACQUIRE: begin
                  if (w_advance) begin
                     r_good_cnt <= '0;
                     r_tmo_cnt  <= '0;
                     if (r_lgcoeff < COEF_HI) begin
                        r_lgcoeff <= r_lgcoeff + 5'd1;
                     end else begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                     end
                  end else if (w_eval) begin
                     r_good_cnt <= w_good_win ? w_good_next : 16'd0;
                     r_tmo_cnt  <= w_tmo_next;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_ld      = r_ld;
   assign o_step    = r_step;
   assign o_lgcoeff = r_lgcoeff;
   assign o_locked  = r_locked;
   assign o_lost    = r_lost;
   assign o_state   = r_state;

`ifdef SDPLL_LOCK_CTRL_STATS_EN
   logic [15:0] r_relock_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_relock_cnt <= '0;
      end else if (r_lost && (r_relock_cnt != 16'hFFFF)) begin
         r_relock_cnt <= r_relock_cnt + 16'd1;
      end
   end

   assign o_relock_count = r_relock_cnt;
`else
   assign o_relock_count = 16'd0;
`endif

endmodule
